// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared state types for the output holder blocks
package types_pkg;

   // Single-entry holder state, kept for the original holder.
   typedef enum logic [0:0] {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } holder_state_t;

   typedef enum logic [1:0] {
      OF_EMPTY = 2'd0,
      OF_READY = 2'd1,
      OF_FULL  = 2'd2
   } output_fifo_state_t;

   function automatic output_fifo_state_t of_decode(input int unsigned cnt,
                                                    input int unsigned depth);
      if (cnt == 0)
         return OF_EMPTY;
      else if (cnt == depth)
         return OF_FULL;
      else
         return OF_READY;
   endfunction

endpackage

// File: rtl/output_fifo_mem.sv
// rtl/output_fifo_mem.sv - storage array with one write port and async read
module output_fifo_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are qualified by the holder's count, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/output_fifo_holder.sv
// rtl/output_fifo_holder.sv - DEPTH-entry FIFO holding encryption results for the output mux
module output_fifo_holder
   import types_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_in_pulse,
   input  logic                       read_ack,
   input  logic                       flush,
   output logic [DATA_W-1:0]          data_out,
   output output_fifo_state_t         holder_state,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("output_fifo_holder: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] head_word;
   logic              is_empty;
   logic              is_full;
   logic              do_push;
   logic              do_pop;
   logic              do_drop;

   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_CNT);

   // A full FIFO still accepts a pulse when the head is popped in the same cycle.
   assign do_pop  = !flush && read_ack && !is_empty;
   assign do_push = !flush && data_in_pulse && (!is_full || read_ack);
   assign do_drop = !flush && data_in_pulse && is_full && !read_ack;

   output_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (head_word)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (do_pop && !do_push)
            count <= count - CNT_W'(1);
         if (do_drop)
            overflow <= 1'b1;
      end
   end

   assign data_out = is_empty ? '0 : head_word;

   always_comb begin
      holder_state = of_decode(32'(count), DEPTH);
   end

endmodule

// File: tb/tb_output_fifo_holder.sv
// tb/tb_output_fifo_holder.sv - directed self-checking bench for output_fifo_holder
module tb_output_fifo_holder;
   import types_pkg::*;

   logic               clk;
   logic               nrst;
   logic [7:0]         data_in;
   logic               data_in_pulse;
   logic               read_ack;
   logic               flush;
   logic [7:0]         data_out;
   output_fifo_state_t holder_state;
   logic [2:0]         count;
   logic               overflow;

   int n_cmp;
   int n_mis;

   output_fifo_holder #(
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .data_in       (data_in),
      .data_in_pulse (data_in_pulse),
      .read_ack      (read_ack),
      .flush         (flush),
      .data_out      (data_out),
      .holder_state  (holder_state),
      .count         (count),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] d, input logic [2:0] c,
                            input output_fifo_state_t s, input logic ov);
      check_val({tag, ".data_out"}, 32'(data_out), 32'(d));
      check_val({tag, ".count"}, 32'(count), 32'(c));
      check_val({tag, ".state"}, 32'(holder_state), 32'(s));
      check_val({tag, ".overflow"}, 32'(overflow), 32'(ov));
   endtask

   // Apply one cycle of strobes, sample 1 time unit after the edge.
   task automatic step(input logic p, input logic [7:0] d, input logic a, input logic f);
      data_in       = d;
      data_in_pulse = p;
      read_ack      = a;
      flush         = f;
      @(posedge clk);
      #1;
      data_in_pulse = 1'b0;
      read_ack      = 1'b0;
      flush         = 1'b0;
      data_in       = 8'h00;
   endtask

   task automatic fill4;
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
   endtask

   logic [7:0] exp_q [4];
   logic [7:0] v;

   initial begin
      n_cmp = 0;
      n_mis = 0;
      nrst = 1'b0;
      data_in = 8'h00;
      data_in_pulse = 1'b0;
      read_ack = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 8'h00, 3'd0, OF_EMPTY, 1'b0);
      nrst = 1'b1;

      // Single word in and out
      step(1, 8'hA5, 0, 0);
      check_all("single_in", 8'hA5, 3'd1, OF_READY, 1'b0);
      step(0, 8'h00, 1, 0);
      check_all("single_out", 8'h00, 3'd0, OF_EMPTY, 1'b0);

      // Fill, then drain in order with one extra ack
      fill4();
      check_all("full", 8'h11, 3'd4, OF_FULL, 1'b0);
      exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         check_val("drain.head", 32'(data_out), 32'(exp_q[i]));
         step(0, 8'h00, 1, 0);
         check_val("drain.count", 32'(count), 32'(3 - i));
      end
      check_all("drained", 8'h00, 3'd0, OF_EMPTY, 1'b0);
      step(0, 8'h00, 1, 0);
      check_all("extra_ack", 8'h00, 3'd0, OF_EMPTY, 1'b0);

      // Overflow on full, cleared by flush
      fill4();
      step(1, 8'h55, 0, 0);
      check_all("overflow", 8'h11, 3'd4, OF_FULL, 1'b1);
      step(0, 8'h00, 0, 0);
      check_val("overflow.sticky", 32'(overflow), 32'd1);
      step(0, 8'h00, 0, 1);
      check_all("flush", 8'h00, 3'd0, OF_EMPTY, 1'b0);

      // Write and pop together while full
      fill4();
      step(1, 8'h66, 1, 0);
      check_all("full_wr_pop", 8'h22, 3'd4, OF_FULL, 1'b0);
      exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
      for (int i = 0; i < 4; i++) begin
         check_val("drain2.head", 32'(data_out), 32'(exp_q[i]));
         step(0, 8'h00, 1, 0);
      end
      check_all("drained2", 8'h00, 3'd0, OF_EMPTY, 1'b0);

      // Empty pulse+ack, then flush beats pulse
      step(1, 8'h77, 1, 0);
      check_all("empty_wr_ack", 8'h77, 3'd1, OF_READY, 1'b0);
      step(0, 8'h00, 0, 1);
      step(1, 8'h88, 0, 1);
      check_all("flush_pulse", 8'h00, 3'd0, OF_EMPTY, 1'b0);

      // Three fill/drain rounds of three words to wrap the pointers
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            v = 8'(8'h30 * r + i + 1);
            step(1, v, 0, 0);
         end
         check_val("wrap.count", 32'(count), 32'd3);
         check_val("wrap.state", 32'(holder_state), 32'(OF_READY));
         for (int i = 0; i < 3; i++) begin
            v = 8'(8'h30 * r + i + 1);
            check_val("wrap.head", 32'(data_out), 32'(v));
            step(0, 8'h00, 1, 0);
         end
         check_val("wrap.empty", 32'(count), 32'd0);
      end

      // Fill, overflow, then assert reset away from the clock edge
      fill4();
      step(1, 8'h99, 0, 0);
      check_all("pre_reset", 8'h11, 3'd4, OF_FULL, 1'b1);
      #1;
      nrst = 1'b0;
      #1;
      check_all("async_reset", 8'h00, 3'd0, OF_EMPTY, 1'b0);
      #1;
      nrst = 1'b1;
      step(1, 8'hC3, 0, 0);
      check_all("post_reset", 8'hC3, 3'd1, OF_READY, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/output_fifo_holder.md
# output_fifo_holder

Parametrised successor to the single-entry output holder. Captures pulsed results from the encryption block into a DEPTH-entry FIFO and presents the oldest entry on a stable output until the interface FSM acknowledges it. Sits between the encryption block and the output mux, and reports occupancy and overflow to the interface FSM.

## Interface
- DATA_W, 8, width of each captured word
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- data_in  in  DATA_W  word from encryption block
- data_in_pulse  in  1  one-cycle strobe; data_in is valid this cycle
- read_ack  in  1  one-cycle strobe from interface FSM; head word has been read
- flush  in  1  interface FSM is idle; discard all contents
- data_out  out  DATA_W  head (oldest) word; 0 when empty
- holder_state  out  output_fifo_state_t  OF_EMPTY / OF_READY / OF_FULL
- count  out  $clog2(DEPTH+1)  number of valid entries
- overflow  out  1  sticky; a pulse was dropped because the FIFO was full

## Operation
- Registered storage mem[DEPTH], wr_ptr, rd_ptr (width $clog2(DEPTH)), count.
- Pointers wrap modulo DEPTH by natural overflow; count ranges 0..DEPTH.
- Priority each cycle: flush > (read_ack, data_in_pulse).
- flush: wr_ptr, rd_ptr, count ← 0; overflow ← 0. Any simultaneous pulse or ack is discarded.
- read_ack with count>0: rd_ptr+1, count−1. With count==0: ignored, no state change.
- data_in_pulse with count<DEPTH: mem[wr_ptr] ← data_in, wr_ptr+1, count+1.
- data_in_pulse with count==DEPTH and no read_ack: word dropped, overflow ← 1, contents unchanged.
- Simultaneous pulse and ack with count>0, including full: write and pop both occur, count unchanged, no overflow.
- Simultaneous pulse and ack with count==0: the write occurs and the ack is ignored, so count becomes 1.
- holder_state is decoded from count: 0→OF_EMPTY, DEPTH→OF_FULL, otherwise OF_READY.
- data_out = (count==0) ? 0 : mem[rd_ptr]. Combinational from registers, so glitch-free with respect to inputs.
- overflow stays set until flush or reset.

## Timing
- Reset, asynchronous: data_out=0, count=0, holder_state=OF_EMPTY, overflow=0. Pointers are 0; mem need not be cleared.
- Latency: a pulse into an empty FIFO at edge N gives data_out=data_in and OF_READY from after edge N.
- read_ack at edge N: the next word, or 0 if the FIFO is now empty, appears after edge N.
- Throughput: one write and one pop per cycle.
- Strobes are sampled only at posedge clk. A strobe held high for k cycles counts as k events.
- Reset asserted mid-operation discards all contents immediately. Operation resumes on the first edge after deassertion.

## Structure
- types_pkg gains typedef enum output_fifo_state_t {OF_EMPTY, OF_READY, OF_FULL}. The existing single-entry state type is left unchanged.
- One sub-module: output_fifo_mem (DATA_W, DEPTH). It holds the storage array, with write port (we, waddr, wdata) and async read (raddr → rdata).
- Pointer, count and flag logic live in output_fifo_holder.
- An elaboration-time assertion rejects DEPTH that is not a power of two or is <2.

## Test plan
- Reset, then pulse 0xA5 → next cycle data_out=0xA5, count=1, OF_READY. Then read_ack → data_out=0, OF_EMPTY.
- DEPTH=4: pulse 0x11,0x22,0x33,0x44 → OF_FULL, count=4. Five acks return 0x11..0x44 in order; the fifth ack is ignored and count stays 0.
- Full FIFO, pulse 0x55 with no ack → overflow=1, data_out still 0x11, count=4. Then flush → count=0, overflow=0.
- Full FIFO, pulse 0x66 and read_ack in the same cycle → count=4, head=0x22, no overflow. Drain to confirm 0x66 is last.
- Empty FIFO, pulse+ack same cycle → count=1. Flush+pulse same cycle → count=0.
- Fill 3 entries, wrap pointers over 3 fill/drain rounds, and assert nrst mid-stream → all outputs return to reset values asynchronously.
